// File: rtl/wb_slave_mem_param_if.sv
// rtl/wb_slave_mem_param_if.sv - Wishbone B4 classic single-transfer bus bundle
interface wb_slave_mem_param_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic [AW-1:0]   ADR_I;
  logic [DW-1:0]   DAT_I;
  logic [DW/8-1:0] SEL_I;
  logic            WE_I;
  logic            STB_I;
  logic            CYC_I;
  logic [DW-1:0]   DAT_O;
  logic            ACK_O;
  logic            ERR_O;

  modport master (
    output ADR_I, DAT_I, SEL_I, WE_I, STB_I, CYC_I,
    input  DAT_O, ACK_O, ERR_O
  );

  modport slave (
    input  ADR_I, DAT_I, SEL_I, WE_I, STB_I, CYC_I,
    output DAT_O, ACK_O, ERR_O
  );
endinterface

// File: rtl/wb_slave_mem_param.sv
// rtl/wb_slave_mem_param.sv - parametrised Wishbone classic slave with word memory
module wb_slave_mem_param #(
  parameter int DW          = 32,
  parameter int DEPTH       = 256,
  parameter int AW          = 32,
  parameter int WAIT_STATES = 0
) (
  input logic                 CLK_I,
  input logic                 RST_I,
  wb_slave_mem_param_if.slave bus
);
  localparam int SW  = DW / 8;
  localparam int BSH = (SW > 1) ? $clog2(SW) : 0;
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_TERM} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      r_cnt;
  logic [AW-1:0]   r_adr;
  logic [DW-1:0]   r_dat_i;
  logic [SW-1:0]   r_sel;
  logic            r_we;
  logic [DW-1:0]   r_mem [DEPTH];
  logic [DW-1:0]   r_dat_o;
  logic            r_ack;
  logic            r_err;

  logic            w_idle;
  logic            w_req;
  logic            w_term;
  logic [AW-1:0]   w_adr;
  logic [DW-1:0]   w_dat;
  logic [SW-1:0]   w_sel;
  logic            w_we;
  logic [AW-1:0]   w_idx_full;
  logic [IW-1:0]   w_idx;
  logic            w_in_range;

  assign w_idle = (r_state == S_IDLE);
  assign w_req  = bus.CYC_I & bus.STB_I;

  // With zero wait states the access happens at the accepting edge, so use the live bus.
  assign w_adr = w_idle ? bus.ADR_I : r_adr;
  assign w_dat = w_idle ? bus.DAT_I : r_dat_i;
  assign w_sel = w_idle ? bus.SEL_I : r_sel;
  assign w_we  = w_idle ? bus.WE_I  : r_we;

  assign w_idx_full = w_adr >> BSH;
  assign w_idx      = w_idx_full[IW-1:0];
  assign w_in_range = 64'(w_idx_full) < 64'(DEPTH);

  assign w_term = (w_idle & w_req & (WAIT_STATES == 0)) |
                  ((r_state == S_WAIT) & bus.CYC_I & (r_cnt == 4'd0));

  always_ff @(posedge CLK_I) begin
    if (!RST_I) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_req) w_next = (WAIT_STATES > 0) ? S_WAIT : S_TERM;
      S_WAIT: begin
        if (!bus.CYC_I)          w_next = S_IDLE;
        else if (r_cnt == 4'd0)  w_next = S_TERM;
      end
      S_TERM:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      r_cnt   <= 4'd0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_dat_o <= '0;
    end else begin
      r_ack   <= w_term & w_in_range;
      r_err   <= w_term & ~w_in_range;
      r_dat_o <= (w_term & w_in_range & ~w_we) ? r_mem[w_idx] : '0;
      if (w_idle & w_req) begin
        r_adr   <= bus.ADR_I;
        r_dat_i <= bus.DAT_I;
        r_sel   <= bus.SEL_I;
        r_we    <= bus.WE_I;
        r_cnt   <= (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
      end else if ((r_state == S_WAIT) && bus.CYC_I && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // Memory is deliberately outside reset; an asserted reset still blocks the write.
  always_ff @(posedge CLK_I) begin
    if (RST_I && w_term && w_in_range && w_we) begin
      for (int b = 0; b < SW; b++) begin
        if (w_sel[b]) r_mem[w_idx][8*b +: 8] <= w_dat[8*b +: 8];
      end
    end
  end

  assign bus.DAT_O = r_dat_o;
  assign bus.ACK_O = r_ack;
  assign bus.ERR_O = r_err;
endmodule

// File: tb/tb_wb_slave_mem_param.sv
// tb/tb_wb_slave_mem_param.sv - bench for wb_slave_mem_param, zero and three wait states
module tb_wb_slave_mem_param;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          which = 2;
  logic [31:0] m_adr = '0;
  logic [31:0] m_dat = '0;
  logic [3:0]  m_sel = '0;
  logic        m_we  = 1'b0;
  logic        m_stb = 1'b0;
  logic        m_cyc = 1'b0;
  int          checks = 0;
  int          errors = 0;

  logic [31:0] ref_mem [256];
  logic        ref_ok  [256];

  wb_slave_mem_param_if #(.DW(32), .AW(32)) b0 ();
  wb_slave_mem_param_if #(.DW(32), .AW(32)) b3 ();

  assign b0.ADR_I = m_adr;  assign b3.ADR_I = m_adr;
  assign b0.DAT_I = m_dat;  assign b3.DAT_I = m_dat;
  assign b0.SEL_I = m_sel;  assign b3.SEL_I = m_sel;
  assign b0.WE_I  = m_we;   assign b3.WE_I  = m_we;
  assign b0.STB_I = m_stb;  assign b3.STB_I = m_stb;
  assign b0.CYC_I = m_cyc & (which != 1);
  assign b3.CYC_I = m_cyc & (which != 0);

  wire        o_ack = (which == 1) ? b3.ACK_O : b0.ACK_O;
  wire        o_err = (which == 1) ? b3.ERR_O : b0.ERR_O;
  wire [31:0] o_dat = (which == 1) ? b3.DAT_O : b0.DAT_O;

  wb_slave_mem_param #(.DW(32), .DEPTH(256), .AW(32), .WAIT_STATES(0)) dut0 (
    .CLK_I(clk), .RST_I(rst), .bus(b0));
  wb_slave_mem_param #(.DW(32), .DEPTH(256), .AW(32), .WAIT_STATES(3)) dut3 (
    .CLK_I(clk), .RST_I(rst), .bus(b3));

  always #5 clk = ~clk;

  // Runs one single transfer; returns termination cycle (0 = none within budget).
  task automatic xfer(input int w, input logic we, input logic [31:0] adr,
                      input logic [31:0] dat, input logic [3:0] sel,
                      output int lat, output logic ack, output logic err,
                      output logic [31:0] dato, output logic after);
    which = w; m_we = we; m_adr = adr; m_dat = dat; m_sel = sel;
    m_cyc = 1'b1; m_stb = 1'b1;
    @(posedge clk); #1;
    m_stb = 1'b0;
    lat = 0; ack = 1'b0; err = 1'b0; dato = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (o_ack || o_err) begin
        lat = k; ack = o_ack; err = o_err; dato = o_dat;
        break;
      end
      @(posedge clk); #1;
    end
    m_cyc = 1'b0;
    @(negedge clk);
    after = o_ack | o_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    which = 2; m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_adr = 32'h10; m_sel = 4'hF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({b0.ACK_O, b0.ERR_O, b3.ACK_O, b3.ERR_O} !== 4'b0 || b0.DAT_O !== 32'h0 || b3.DAT_O !== 32'h0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: ack0=%b err0=%b dat0=%h ack3=%b err3=%b dat3=%h, want all 0",
                 c, b0.ACK_O, b0.ERR_O, b0.DAT_O, b3.ACK_O, b3.ERR_O, b3.DAT_O);
      end
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (b0.ACK_O !== 1'b1 || b0.ERR_O !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_request: ack=%b err=%b, want ack=1 err=0", b0.ACK_O, b0.ERR_O);
    end
    m_cyc = 1'b0; m_stb = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int lat; logic a, e, af; logic [31:0] d;
    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, a, e, d, af);
    checks++;
    if (lat !== 1 || a !== 1'b1 || e !== 1'b0 || af !== 1'b0) begin
      errors++;
      $display("FAIL write_ack: lat=%0d ack=%b err=%b after=%b, want lat=1 ack=1 err=0 after=0", lat, a, e, af);
    end
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, lat, a, e, d, af);
    checks++;
    if (lat !== 1 || a !== 1'b1 || d !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_back: lat=%0d ack=%b dat=%h, want lat=1 ack=1 dat=deadbeef", lat, a, d);
    end
  endtask

  task automatic test_byte_sel();
    int lat; logic a, e, af; logic [31:0] d;
    xfer(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, lat, a, e, d, af);
    xfer(0, 1'b0, 32'h12, 32'h0, 4'h0, lat, a, e, d, af);
    checks++;
    if (a !== 1'b1 || d !== 32'hDE22BE44) begin
      errors++;
      $display("FAIL byte_sel: ack=%b dat=%h, want ack=1 dat=de22be44", a, d);
    end
    xfer(0, 1'b1, 32'h10, 32'h99999999, 4'h0, lat, a, e, d, af);
    checks++;
    if (a !== 1'b1 || e !== 1'b0) begin
      errors++;
      $display("FAIL sel_zero_ack: ack=%b err=%b, want ack=1 err=0", a, e);
    end
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, lat, a, e, d, af);
    checks++;
    if (d !== 32'hDE22BE44) begin
      errors++;
      $display("FAIL sel_zero_nochange: dat=%h, want de22be44", d);
    end
  endtask

  task automatic test_wait_states();
    int lat; logic a, e, af; logic [31:0] d;
    xfer(1, 1'b1, 32'h30, 32'hA5A50001, 4'hF, lat, a, e, d, af);
    checks++;
    if (lat !== 4 || a !== 1'b1 || af !== 1'b0) begin
      errors++;
      $display("FAIL ws3_write: lat=%0d ack=%b after=%b, want lat=4 ack=1 after=0", lat, a, af);
    end
    xfer(1, 1'b0, 32'h30, 32'h0, 4'hF, lat, a, e, d, af);
    checks++;
    if (lat !== 4 || a !== 1'b1 || e !== 1'b0 || d !== 32'hA5A50001) begin
      errors++;
      $display("FAIL ws3_read: lat=%0d ack=%b err=%b dat=%h, want lat=4 ack=1 err=0 dat=a5a50001", lat, a, e, d);
    end
  endtask

  task automatic test_out_of_range();
    int lat; logic a, e, af; logic [31:0] d;
    xfer(0, 1'b1, 32'h0, 32'h01020304, 4'hF, lat, a, e, d, af);
    xfer(0, 1'b0, 32'h400, 32'h0, 4'hF, lat, a, e, d, af);
    checks++;
    if (lat !== 1 || a !== 1'b0 || e !== 1'b1 || d !== 32'h0 || af !== 1'b0) begin
      errors++;
      $display("FAIL oor_read: lat=%0d ack=%b err=%b dat=%h after=%b, want lat=1 ack=0 err=1 dat=0 after=0", lat, a, e, d, af);
    end
    xfer(0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, lat, a, e, d, af);
    checks++;
    if (a !== 1'b0 || e !== 1'b1) begin
      errors++;
      $display("FAIL oor_write: ack=%b err=%b, want ack=0 err=1", a, e);
    end
    xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, lat, a, e, d, af);
    checks++;
    if (d !== 32'h01020304) begin
      errors++;
      $display("FAIL oor_no_alias: dat=%h, want 01020304", d);
    end
  endtask

  task automatic test_abort();
    int lat; logic a, e, af; logic [31:0] d; int seen;
    xfer(1, 1'b1, 32'h20, 32'h12345678, 4'hF, lat, a, e, d, af);
    which = 1; m_we = 1'b1; m_adr = 32'h20; m_dat = 32'hCAFEF00D; m_sel = 4'hF;
    m_cyc = 1'b1; m_stb = 1'b1;
    @(posedge clk); #1;
    m_stb = 1'b0;
    seen = 0;
    @(negedge clk);
    if (o_ack || o_err) seen++;
    @(posedge clk); #1;
    m_cyc = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (o_ack || o_err) seen++;
    end
    @(posedge clk); #1;
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_term: terminations=%0d, want 0", seen);
    end
    xfer(1, 1'b0, 32'h20, 32'h0, 4'hF, lat, a, e, d, af);
    checks++;
    if (a !== 1'b1 || d !== 32'h12345678) begin
      errors++;
      $display("FAIL abort_no_write: ack=%b dat=%h, want ack=1 dat=12345678", a, d);
    end
  endtask

  task automatic test_reset_mid_wait();
    int lat; logic a, e, af; logic [31:0] d; int seen;
    xfer(1, 1'b1, 32'h40, 32'h0BADF00D, 4'hF, lat, a, e, d, af);
    which = 1; m_we = 1'b1; m_adr = 32'h40; m_dat = 32'h55555555; m_sel = 4'hF;
    m_cyc = 1'b1; m_stb = 1'b1;
    @(posedge clk); #1;
    m_stb = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (o_ack || o_err) seen++;
      @(posedge clk); #1;
    end
    m_cyc = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_mid_wait_term: terminations=%0d, want 0", seen);
    end
    xfer(1, 1'b0, 32'h40, 32'h0, 4'hF, lat, a, e, d, af);
    checks++;
    if (lat !== 4 || d !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL reset_mid_wait_data: lat=%0d dat=%h, want lat=4 dat=0badf00d", lat, d);
    end
  endtask

  task automatic test_back_to_back();
    logic got; logic want;
    which = 0; m_we = 1'b0; m_adr = 32'h10; m_sel = 4'hF;
    m_cyc = 1'b1; m_stb = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      got  = o_ack;
      want = (k % 2) == 0;
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: ack=%b, want %b", k, got, want);
      end
      @(posedge clk); #1;
    end
    m_cyc = 1'b0; m_stb = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int lat; logic a, e, af; logic [31:0] d;
    int pool [8];
    int idx; logic we; logic [31:0] adr, dat, exp; logic [3:0] sel; logic oor;
    for (int i = 0; i < 256; i++) ref_ok[i] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pool[i] = $urandom_range(0, 255);
      dat = $urandom;
      xfer(0, 1'b1, 32'(pool[i]) << 2, dat, 4'hF, lat, a, e, d, af);
      ref_mem[pool[i]] = dat; ref_ok[pool[i]] = 1'b1;
    end
    for (int n = 0; n < 60; n++) begin
      oor = ($urandom_range(0, 9) == 0);
      idx = oor ? $urandom_range(256, 5000) : pool[$urandom_range(0, 7)];
      adr = (32'(idx) << 2) | 32'($urandom_range(0, 3));
      we  = $urandom_range(0, 1) == 1;
      sel = 4'($urandom_range(0, 15));
      dat = $urandom;
      xfer(0, we, adr, dat, sel, lat, a, e, d, af);
      exp = '0;
      if (!oor && !we) exp = ref_mem[idx];
      checks++;
      if (lat !== 1 || a !== !oor || e !== oor || af !== 1'b0 || (!we && d !== exp)) begin
        errors++;
        $display("FAIL random op %0d adr=%h we=%b: lat=%0d ack=%b err=%b dat=%h after=%b, want lat=1 ack=%b err=%b dat=%h",
                 n, adr, we, lat, a, e, d, af, !oor, oor, exp);
      end
      if (!oor && we) begin
        for (int b = 0; b < 4; b++) if (sel[b]) ref_mem[idx][8*b +: 8] = dat[8*b +: 8];
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_sel();
    test_wait_states();
    test_out_of_range();
    test_abort();
    test_reset_mid_wait();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
